// File: rtl/seq_mult.sv
// Sequential signed Q1.(n-1) shift-add multiplier: n RUN cycles then a one-cycle done pulse; start ignored while busy.
// Optional SEQ_MULT_ROUND_EN rounds half-up before saturation; otherwise the result is floored.
module seq_mult #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result
);

  localparam int CW = $clog2(n + 1);
  localparam int PW = 2 * n;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        count;
  logic signed [PW-1:0] mcand, acc, acc_nxt, pp, prod;
  logic [n-1:0]         mplier;
  logic [n:0]           scaled;
  logic [n-1:0]         sat;
  logic                 accept, last;

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (count == CW'(1));

  always_ff @(posedge clk) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // The multiplier's MSB carries weight -2^(n-1), so its partial product is subtracted.
  always_comb begin
    pp = '0;
    if (mplier[0]) pp = last ? -mcand : mcand;
    acc_nxt = acc + pp;
  end

`ifdef SEQ_MULT_ROUND_EN
  localparam logic signed [PW-1:0] HALF = PW'(1) << (n - 2);
  assign prod = acc_nxt + HALF;
`else
  assign prod = acc_nxt;
`endif

  // Keeping one extra integer bit exposes overflow as a mismatch of the top two bits.
  always_comb begin
    scaled = prod[PW-1:n-1];
    sat    = scaled[n-1:0];
    if (scaled[n] != scaled[n-1])
      sat = scaled[n] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      result <= '0;
    end else if (accept) begin
      mcand  <= {{n{a[n-1]}}, a};
      mplier <= b;
      acc    <= '0;
      count  <= CW'(n);
    end else if (state == RUN) begin
      acc    <= acc_nxt;
      mcand  <= mcand <<< 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
      if (last) result <= sat;
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Randomized self-checking bench for seq_mult (n=8) against an integer-arithmetic reference model.
module tb_seq_mult;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;

  seq_mult #(.n(8)) dut (
    .clk(clk), .nReset(nReset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] y);
    int xi, yi, p, r;
    xi = $signed(x);
    yi = $signed(y);
    p  = xi * yi;
`ifdef SEQ_MULT_ROUND_EN
    p  = p + 64;
`endif
    r = p >>> 7;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  // One operation from idle: latency, busy length, done pulse width and value.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input string name);
    int cycles;
    logic [7:0] exp;
    exp = model(ta, tb);
    a = ta; b = tb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 20) begin
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_and_done: done=%b while busy, required 0", name, done);
      end
      a = 8'($urandom); b = 8'($urandom);
      cycles++;
      @(negedge clk);
    end
    checks++;
    if (cycles != 8) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, required 8", name, cycles);
    end
    checks++;
    if (done !== 1'b1 || result !== exp) begin
      errors++;
      $display("FAIL %s result: done=%b result=%h, required done=1 result=%h (a=%h b=%h)",
               name, done, result, exp, ta, tb);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b result=%h, required 0 0 %h",
               name, done, busy, result, exp);
    end
  endtask

  task automatic test_reset;
    nReset = 1'b0; start = 1'b1; a = 8'h40; b = 8'h60;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
        errors++;
        $display("FAIL reset cycle%0d: busy=%b done=%b result=%h, required 0 0 00",
                 i, busy, done, result);
      end
    end
    start = 1'b0;
    nReset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    run_op(8'h40, 8'h60, "basic");
  endtask

  task automatic test_rounding;
    run_op(8'h03, 8'h40, "round_pos");
    run_op(8'hFD, 8'h40, "round_neg");
  endtask

  task automatic test_extremes;
    run_op(8'h80, 8'h80, "sat_max");
    run_op(8'h80, 8'h7F, "most_neg");
    run_op(8'h00, 8'h80, "zero");
    run_op(8'hFF, 8'hFF, "minus_one");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) run_op(8'($urandom), 8'($urandom), "random");
  endtask

  // start held high: only operands present on a done cycle (or from idle) are taken.
  task automatic test_back_to_back;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] exp;
    int ndone, gap, guard;
    a = 8'($urandom); b = 8'($urandom); start = 1'b1;
    qa.push_back(a); qb.push_back(b);
    ndone = 0; gap = 0; guard = 0;
    while (ndone < 4 && guard < 60) begin
      @(negedge clk);
      guard++; gap++;
      checks++;
      if (busy === done) begin
        errors++;
        $display("FAIL b2b state: busy=%b done=%b, required exactly one high", busy, done);
      end
      if (done === 1'b1) begin
        exp = model(qa.pop_front(), qb.pop_front());
        checks++;
        if (result !== exp || gap != 9) begin
          errors++;
          $display("FAIL b2b op%0d: result=%h gap=%0d, required result=%h gap=9",
                   ndone, result, gap, exp);
        end
        ndone++; gap = 0;
        a = 8'($urandom); b = 8'($urandom);
        if (ndone < 4) begin
          qa.push_back(a); qb.push_back(b);
        end else begin
          start = 1'b0;
        end
      end else begin
        a = 8'($urandom); b = 8'($urandom);
      end
    end
    checks++;
    if (ndone != 4) begin
      errors++;
      $display("FAIL b2b count: got %0d done pulses, required 4", ndone);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid;
    a = 8'h55; b = 8'h33; start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL midrst busy%0d: busy=%b, required 1", i, busy);
      end
    end
    nReset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
      errors++;
      $display("FAIL midrst after: busy=%b done=%b result=%h, required 0 0 00", busy, done, result);
    end
    nReset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst no_done: cycle %0d busy=%b done=%b, required 0 0", i, busy, done);
      end
    end
    run_op(8'hC3, 8'h5A, "post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_extremes();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
